// File: rtl/sample_latch.sv
// sample_latch: double-buffered serial-to-parallel capture between a serial DAC input and an I2S serializer
module sample_latch #(
    parameter int WIDTH = 18
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_data,
    input  logic             i_ad_latch,
    input  logic             i_i2s_latch,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] hold;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift  <= '0;
            hold   <= '0;
            o_data <= '0;
        end else begin
            shift <= {shift[WIDTH-2:0], i_data};
            if (i_ad_latch) hold <= shift;
            if (i_i2s_latch) o_data <= hold;
        end
    end
endmodule

// File: tb/tb_sample_latch.sv
// tb_sample_latch: directed plus randomized checks of sample_latch against a bit-history reference model
module tb_sample_latch;
    localparam int W = 18;
    logic         i_clk = 0;
    logic         i_rst = 1;
    logic         i_data = 0;
    logic         i_ad_latch = 0;
    logic         i_i2s_latch = 0;
    logic [W-1:0] o_data;
    int           vectors = 0;
    int           errors = 0;
    bit           hist[$];
    logic [W-1:0] m_hold = '0;
    logic [W-1:0] m_out = '0;

    sample_latch #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data),
        .i_ad_latch(i_ad_latch), .i_i2s_latch(i_i2s_latch), .o_data(o_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // the most recent W serial bits, most recent as LSB, zero-padded after reset
    function automatic logic [W-1:0] recent_bits();
        logic [W-1:0] v = '0;
        int lo = (hist.size() > W) ? hist.size() - W : 0;
        for (int i = lo; i < hist.size(); i++) v = (v << 1) + W'(hist[i]);
        return v;
    endfunction

    task automatic step(input string tag, input bit d, input bit ad, input bit i2s, input bit rst);
        logic [W-1:0] sh;
        @(negedge i_clk);
        i_data = d; i_ad_latch = ad; i_i2s_latch = i2s; i_rst = rst;
        @(posedge i_clk);
        sh = recent_bits();
        if (rst) begin
            hist.delete();
            m_hold = '0;
            m_out = '0;
        end else begin
            if (i2s) m_out = m_hold;
            if (ad) m_hold = sh;
            hist.push_back(d);
            if (hist.size() > 64) void'(hist.pop_front());
        end
        #1 check(tag, o_data, m_out);
    endtask

    task automatic shift_in(input string tag, input logic [W-1:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, val[i], 0, 0, 0);
    endtask

    initial begin
        step("reset", 1'($urandom), 1'($urandom), 1'($urandom), 1);
        step("reset", 1'($urandom), 1'($urandom), 1'($urandom), 1);
        check("reset_zero", o_data, '0);
        step("i2s_no_ad", 0, 0, 1, 0);
        check("i2s_no_ad_zero", o_data, '0);
        shift_in("basic_shift", 18'h2AAAA, W);
        step("basic_ad", 0, 1, 0, 0);
        check("basic_before_i2s", o_data, '0);
        step("basic_i2s", 0, 0, 1, 0);
        check("basic_out", o_data, 18'h2AAAA);
        for (int i = 0; i < 20; i++) step("long_ones", 1, 0, 0, 0);
        shift_in("long_tail", 18'h00001, W);
        step("long_ad", 0, 1, 0, 0);
        step("long_i2s", 0, 0, 1, 0);
        check("long_out", o_data, 18'h00001);
        shift_in("db_a", 18'h2AAAA, W);
        step("db_ad_a", 0, 1, 0, 0);
        step("db_i2s_a", 0, 0, 1, 0);
        check("db_out_a", o_data, 18'h2AAAA);
        shift_in("db_b", 18'h15555, W);
        step("db_ad_b", 0, 1, 0, 0);
        check("db_hold_a", o_data, 18'h2AAAA);
        step("db_i2s_b", 0, 0, 1, 0);
        check("db_out_b", o_data, 18'h15555);
        shift_in("db_c", 18'h3F0F0, 5);
        step("db_mid_i2s", 1, 0, 1, 0);
        shift_in("db_c", 18'h3F0F0, 4);
        check("db_mid_same", o_data, 18'h15555);
        shift_in("sim_a", 18'h2AAAA, W);
        step("sim_ad_a", 0, 1, 0, 0);
        shift_in("sim_b", 18'h15555, W);
        step("sim_both", 0, 1, 1, 0);
        check("sim_old_hold", o_data, 18'h2AAAA);
        step("sim_i2s", 0, 0, 1, 0);
        check("sim_new_hold", o_data, 18'h15555);
        shift_in("rm_a", 18'h2AAAA, W);
        step("rm_ad", 0, 1, 0, 0);
        step("rm_i2s", 0, 0, 1, 0);
        check("rm_pre", o_data, 18'h2AAAA);
        shift_in("rm_partial", 18'h1FF, 9);
        step("rm_reset", 1, 0, 0, 1);
        check("rm_reset_zero", o_data, '0);
        shift_in("rm_four", 18'hB, 4);
        step("rm_ad4", 0, 1, 0, 0);
        step("rm_i2s4", 0, 0, 1, 0);
        check("rm_four_bits", o_data, 18'h0000B);
        for (int i = 0; i < 3000; i++)
            step("random", 1'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sample_latch.md
Name: sample_latch

Overview:
- Serial-to-parallel sample capture between an AD1868-style serial DAC input and an I2S output serializer.
- Serial data is shifted in MSB first, one bit per clock.
- On an AD latch pulse, the most recent WIDTH bits are moved into a holding register.
- On an I2S latch, the holding register is moved to the parallel output. The output therefore stays stable while the serial side is loading the next sample (double buffering).

Parameters:
- WIDTH, 18, sample width in bits; also the width of the shift register, holding register and o_data.

Ports:
- i_clk  input  1  system/bit clock; all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_data  input  1  serial sample data, MSB first, sampled every rising edge of i_clk.
- i_ad_latch  input  1  one-clock pulse, high for one cycle; captures the shift register into the holding register.
- i_i2s_latch  input  1  level-sampled strobe; while high at a rising edge, transfers the holding register to o_data.
- o_data  output  WIDTH  latched parallel sample for the I2S side.

Behaviour:
- Reset: at a rising edge with i_rst=1, clear the shift register, the holding register and o_data to 0. Reset overrides all other inputs in that cycle.
- Shift:
  - Every rising edge with i_rst=0: shift <= {shift[WIDTH-2:0], i_data}.
  - Shifting is unconditional; it continues during latch cycles.
  - Bits older than WIDTH clocks are discarded.
  - The last bit shifted in is the LSB.
- AD capture:
  - At a rising edge with i_ad_latch=1: hold <= shift.
  - shift is the pre-edge value, i.e. the WIDTH bits sampled on the previous WIDTH edges. The i_data bit sampled on the latch edge itself is not included; it enters the next sample.
- I2S transfer:
  - At a rising edge with i_i2s_latch=1: o_data <= hold, using the pre-edge hold value.
  - If i_i2s_latch is high for several edges, o_data follows hold on each of them.
- Simultaneous i_ad_latch and i_i2s_latch: o_data receives the old hold value, and hold receives the new shift value in the same edge. No combinational bypass.
- Otherwise o_data holds its value indefinitely. Latency from i_ad_latch to o_data is at least one edge later, whenever i_i2s_latch occurs.
- No handshake and no overflow detection:
  - Multiple AD latches without an I2S latch: only the last one survives.
  - Multiple I2S latches without an AD latch: the same sample is re-output.
- All outputs registered; no combinational path from inputs to o_data.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with random i_data and latches -> o_data=0. After release, an I2S latch with no prior AD latch -> o_data=0.
- Basic capture: shift 18'b10_1010_1010_1010_1010 (0x2AAAA) MSB first, pulse i_ad_latch on the next edge, then pulse i_i2s_latch -> o_data=0x2AAAA. o_data stays 0 until the I2S pulse.
- Overlong stream: shift 20 ones, then 18'h00001, then AD and I2S pulses -> o_data=0x00001; older bits are dropped.
- Double buffering:
  - Capture 0x2AAAA and transfer it to o_data.
  - Shift in 0x15555 and pulse AD only -> o_data stays 0x2AAAA.
  - Pulse I2S -> o_data=0x15555.
  - Pulse I2S mid-way through shifting a third sample -> o_data unchanged at 0x15555.
- Simultaneous latches: with hold=0x2AAAA and shift=0x15555, assert i_ad_latch and i_i2s_latch on the same edge -> o_data=0x2AAAA. A further I2S pulse -> o_data=0x15555.
- Reset mid-operation: assert i_rst after 9 bits of a sample have been shifted, with o_data=0x2AAAA -> o_data=0. An AD+I2S sequence directly after reset with only 4 new bits shifted -> o_data holds exactly those 4 bits in the LSBs, upper bits 0.
